// File: rtl/note_game_pkg.sv
// Shared types and constants for the note scroll game blocks.
package note_game_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 16;

  typedef logic [NUM_COLS-1:0] row_t;
  typedef row_t [NUM_ROWS-1:0] field_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic logic [2:0] popcount4(input row_t v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/hit_judge.sv
// Judgement-window search: per column, the lowest note inside the bottom
// HIT_WIN rows is the one a key press removes.
module hit_judge
  import note_game_pkg::*;
#(
  parameter int HIT_WIN = 2
) (
  input  field_t field,
  input  row_t   hit_req,
  input  logic   en,
  output field_t clear,
  output row_t   hit
);

  always_comb begin
    clear = '0;
    hit   = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (en && hit_req[c]) begin
        for (int r = NUM_ROWS - 1; r >= NUM_ROWS - HIT_WIN; r--) begin
          if (!hit[c] && field[r][c]) begin
            clear[r][c] = 1'b1;
            hit[c]      = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/note_scroll_scheduler.sv
// Falling-note field scheduler: scroll, spawn, hit judgement and field flush.
// Optional score counters are built when NOTE_SCORE_CNT_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting; hits judged, spawns accepted, tick/flush launch work
// ST_SHIFT | one cycle: field moves down one row, pending pattern enters row 0
// ST_FLUSH | clears one row per cycle, rows 0..15, then back to idle
module note_scroll_scheduler
  import note_game_pkg::*;
#(
  parameter int HIT_WIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_scroll,
  input  logic        run,
  input  logic        flush,
  input  logic        spawn_valid,
  input  logic [3:0]  spawn_pattern,
  output logic        spawn_ready,
  input  logic [3:0]  hit_req,
  output logic [63:0] block_rows,
  output logic [3:0]  hit_ok,
  output logic [3:0]  miss,
  output logic        busy
`ifdef NOTE_SCORE_CNT_EN
  ,
  output logic [15:0] score_hits,
  output logic [15:0] score_miss
`endif
);

  state_t     state, state_nxt;
  field_t     rows, rows_nxt, rows_hit, clear;
  row_t       pending, pending_nxt;
  logic       pending_valid, pending_valid_nxt;
  logic [3:0] flush_row, flush_row_nxt;
  row_t       hit, miss_nxt;
  logic       hit_en, xfer;

  assign spawn_ready = !pending_valid && (state != ST_FLUSH);
  assign xfer        = spawn_valid && spawn_ready;
  assign busy        = (state != ST_IDLE);
  assign block_rows  = rows;

  // A flush request wins over a same-cycle key press, so FLUSH never shows a hit.
  assign hit_en = run && ((state == ST_SHIFT) || ((state == ST_IDLE) && !flush));

  hit_judge #(.HIT_WIN(HIT_WIN)) u_hit_judge (
    .field   (rows),
    .hit_req (hit_req),
    .en      (hit_en),
    .clear   (clear),
    .hit     (hit)
  );

  assign rows_hit = rows & ~clear;

  always_comb begin
    state_nxt         = state;
    rows_nxt          = rows;
    pending_nxt       = pending;
    pending_valid_nxt = pending_valid;
    flush_row_nxt     = flush_row;
    miss_nxt          = '0;
    unique case (state)
      ST_IDLE: begin
        if (flush) begin
          state_nxt         = ST_FLUSH;
          pending_valid_nxt = 1'b0;
          pending_nxt       = '0;
          flush_row_nxt     = '0;
        end else begin
          rows_nxt = rows_hit;
          if (xfer) begin
            pending_valid_nxt = 1'b1;
            pending_nxt       = spawn_pattern;
          end
          if (run && tick_scroll) state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        rows_nxt          = {rows_hit[NUM_ROWS-2:0], (pending_valid ? pending : row_t'(0))};
        miss_nxt          = rows_hit[NUM_ROWS-1];
        // A pattern accepted now waits for the next scroll.
        pending_valid_nxt = xfer;
        if (xfer) pending_nxt = spawn_pattern;
        state_nxt         = ST_IDLE;
      end
      ST_FLUSH: begin
        rows_nxt[flush_row] = '0;
        flush_row_nxt       = flush_row + 4'd1;
        if (flush_row == 4'(NUM_ROWS - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rows          <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      flush_row     <= '0;
      hit_ok        <= '0;
      miss          <= '0;
    end else begin
      state         <= state_nxt;
      rows          <= rows_nxt;
      pending       <= pending_nxt;
      pending_valid <= pending_valid_nxt;
      flush_row     <= flush_row_nxt;
      hit_ok        <= hit;
      miss          <= miss_nxt;
    end
  end

`ifdef NOTE_SCORE_CNT_EN
  logic [16:0] hits_sum, miss_sum;
  logic        flush_entry;

  assign hits_sum    = 17'(score_hits) + 17'(popcount4(hit_ok));
  assign miss_sum    = 17'(score_miss) + 17'(popcount4(miss));
  assign flush_entry = (state == ST_IDLE) && flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_hits <= '0;
      score_miss <= '0;
    end else if (flush_entry) begin
      score_hits <= '0;
      score_miss <= '0;
    end else begin
      score_hits <= hits_sum[16] ? 16'hFFFF : hits_sum[15:0];
      score_miss <= miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_note_scroll_scheduler.sv
// Bench for note_scroll_scheduler: directed scenarios plus random play,
// compared every cycle against a row-array model of the game field.
module tb_note_scroll_scheduler;

  localparam int HIT_WIN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_scroll = 1'b0;
  logic        run = 1'b0;
  logic        flush = 1'b0;
  logic        spawn_valid = 1'b0;
  logic [3:0]  spawn_pattern = 4'h0;
  logic [3:0]  hit_req = 4'h0;
  logic        spawn_ready;
  logic [63:0] block_rows;
  logic [3:0]  hit_ok;
  logic [3:0]  miss;
  logic        busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  note_scroll_scheduler #(.HIT_WIN(HIT_WIN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_scroll   (tick_scroll),
    .run           (run),
    .flush         (flush),
    .spawn_valid   (spawn_valid),
    .spawn_pattern (spawn_pattern),
    .spawn_ready   (spawn_ready),
    .hit_req       (hit_req),
    .block_rows    (block_rows),
    .hit_ok        (hit_ok),
    .miss          (miss),
    .busy          (busy)
  );

  // Model: the field as 16 rows, a one-slot spawn buffer, a flag for a
  // scroll due on the next edge, and the number of flush cycles remaining.
  bit [3:0] m_rows [16];
  bit       m_pv;
  bit [3:0] m_pat;
  bit [3:0] m_hit;
  bit [3:0] m_miss;
  bit       m_shift_due;
  int       m_flush_left;

  task automatic model_reset();
    for (int r = 0; r < 16; r++) m_rows[r] = 4'h0;
    m_pv = 1'b0;
    m_pat = 4'h0;
    m_hit = 4'h0;
    m_miss = 4'h0;
    m_shift_due = 1'b0;
    m_flush_left = 0;
  endtask

  function automatic logic [63:0] m_image();
    logic [63:0] img;
    img = '0;
    for (int r = 0; r < 16; r++) img[4*r +: 4] = m_rows[r];
    return img;
  endfunction

  task automatic apply_hits(output bit [3:0] nh);
    nh = 4'h0;
    for (int c = 0; c < 4; c++) begin
      if (hit_req[c]) begin
        for (int r = 15; r >= 16 - HIT_WIN; r--) begin
          if (m_rows[r][c]) begin
            m_rows[r][c] = 1'b0;
            nh[c] = 1'b1;
            break;
          end
        end
      end
    end
  endtask

  task automatic model_step();
    bit [3:0] nh;
    bit [3:0] nm;
    bit ready;
    bit xfer;
    nh = 4'h0;
    nm = 4'h0;
    ready = !m_pv && (m_flush_left == 0);
    xfer = spawn_valid && ready;
    if (m_flush_left > 0) begin
      m_rows[16 - m_flush_left] = 4'h0;
      m_flush_left--;
    end else if (m_shift_due) begin
      if (run) apply_hits(nh);
      nm = m_rows[15];
      for (int r = 15; r > 0; r--) m_rows[r] = m_rows[r-1];
      m_rows[0] = m_pv ? m_pat : 4'h0;
      m_pv = xfer;
      if (xfer) m_pat = spawn_pattern;
      m_shift_due = 1'b0;
    end else if (flush) begin
      m_flush_left = 16;
      m_pv = 1'b0;
    end else begin
      if (run) apply_hits(nh);
      if (xfer) begin
        m_pv = 1'b1;
        m_pat = spawn_pattern;
      end
      if (run && tick_scroll) m_shift_due = 1'b1;
    end
    m_hit = nh;
    m_miss = nm;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    check("block_rows", block_rows, m_image());
    check("hit_ok", 64'(hit_ok), 64'(m_hit));
    check("miss", 64'(miss), 64'(m_miss));
    check("busy", 64'(busy), 64'(m_shift_due || (m_flush_left > 0)));
    check("spawn_ready", 64'(spawn_ready), 64'(!m_pv && (m_flush_left == 0)));
  endtask

  task automatic cycle(input bit t, input bit rn, input bit fl, input bit sv,
                       input bit [3:0] sp, input bit [3:0] hr);
    tick_scroll = t;
    run = rn;
    flush = fl;
    spawn_valid = sv;
    spawn_pattern = sp;
    hit_req = hr;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic tick();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    idle_cycle();
  endtask

  task automatic async_reset();
    tick_scroll = 1'b0;
    run = 1'b0;
    flush = 1'b0;
    spawn_valid = 1'b0;
    hit_req = 4'h0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rows", block_rows, 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_hit_ok", 64'(hit_ok), 64'h0);
    check("rst_miss", 64'(miss), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
  endtask

  initial begin
    int bcnt;
    model_reset();
    repeat (2) @(negedge clk);
    check("in_reset_rows", block_rows, 64'h0);
    check("in_reset_busy", 64'(busy), 64'h0);
    rst_n = 1'b1;
    #1;
    check("reset_ready", 64'(spawn_ready), 64'h1);
    check("reset_hit_ok", 64'(hit_ok), 64'h0);
    check("reset_miss", 64'(miss), 64'h0);
    compare_all();

    // single note travels to the bottom then falls out
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 4'h0);
    check("spawn_ready_low", 64'(spawn_ready), 64'h0);
    repeat (16) tick();
    check("note_at_row15", block_rows, 64'h1000_0000_0000_0000);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    check("in_shift_busy", 64'(busy), 64'h1);
    idle_cycle();
    check("miss_col0", 64'(miss), 64'h1);
    check("empty_after_miss", block_rows, 64'h0);
    idle_cycle();
    check("miss_one_cycle", 64'(miss), 64'h0);

    // hit a note sitting in row 14
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 4'h0);
    repeat (15) tick();
    check("note_at_row14", block_rows, 64'h0400_0000_0000_0000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0100);
    check("hit_ok_col2", 64'(hit_ok), 64'h4);
    check("row14_cleared", block_rows, 64'h0);
    repeat (3) tick();

    // two stacked notes, one press takes the lower one
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 4'h0);
    tick();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 4'h0);
    repeat (15) tick();
    check("stacked_col1", block_rows, 64'h2200_0000_0000_0000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0010);
    check("hit_ok_col1", 64'(hit_ok), 64'h2);
    check("lower_cleared", block_rows, 64'h0200_0000_0000_0000);
    tick();
    check("upper_moves_down", block_rows, 64'h2000_0000_0000_0000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0010);

    // hit during the scroll cycle beats the miss
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'b1000, 4'h0);
    repeat (16) tick();
    check("col3_at_row15", block_rows, 64'h8000_0000_0000_0000);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b1000);
    check("shift_hit_ok", 64'(hit_ok), 64'h8);
    check("shift_hit_miss", 64'(miss), 64'h0);
    check("shift_hit_rows", block_rows, 64'h0);

    // fill the field, then flush it
    repeat (16) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 4'h0);
      idle_cycle();
    end
    check("field_full", block_rows, 64'hFFFF_FFFF_FFFF_FFFF);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    bcnt = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      bcnt++;
      cycle(1'($urandom % 2), 1'b1, 1'($urandom % 2), 1'($urandom % 2),
            4'($urandom), 4'($urandom));
    end
    check("flush_busy_cycles", 64'(bcnt), 64'd16);
    check("flush_rows_zero", block_rows, 64'h0);
    check("flush_hit_ok", 64'(hit_ok), 64'h0);
    idle_cycle();

    // spawn held valid with two patterns
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 4'h0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 4'h0);
    check("ready_low_held", 64'(spawn_ready), 64'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 4'h0);
    check("ready_low_in_shift", 64'(spawn_ready), 64'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 4'h0);
    check("ready_after_shift", 64'(spawn_ready), 64'h1);
    check("first_in_row0", block_rows, 64'h3);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 4'h0);
    check("second_accepted", 64'(spawn_ready), 64'h0);
    spawn_valid = 1'b0;
    tick();
    check("order_rows01", block_rows, 64'h35);

    // random play, with resets landing inside FLUSH and SHIFT
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
        repeat (3) idle_cycle();
        async_reset();
      end else if (i == 3000) begin
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        async_reset();
      end else begin
        cycle(1'(($urandom % 3) == 0), 1'(($urandom % 8) != 0),
              1'(($urandom % 80) == 0), 1'($urandom % 2),
              4'($urandom), 4'($urandom & $urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_scroll_scheduler.md
NOTE_SCROLL_SCHEDULER -- requirements
Module: note_scroll_scheduler

Interface
REQ-001 Parameter HIT_WIN, default 2, SHALL set the number of bottom rows forming the judgement window (legal 1..16).
REQ-002 clk  in  1  system clock; all state SHALL update on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 tick_scroll  in  1  one-cycle pulse: advance notes one row.
REQ-005 run  in  1  1 = game running; 0 = tick_scroll and hit_req ignored.
REQ-006 flush  in  1  one-cycle pulse: start clearing the whole field.
REQ-007 spawn_valid / spawn_pattern[3:0] / spawn_ready  in/in/out  1/4/1  valid-ready handshake supplying the next row-0 note pattern.
REQ-008 hit_req  in  4  per-column key pulses, bit c = game column c.
REQ-009 block_rows  out  64  field image, row r at bits [4r+3:4r], row 0 top, row 15 bottom, bit c = column c; the LED matrix driver reads it.
REQ-010 hit_ok  out  4  registered one-cycle pulse per column on a successful hit.
REQ-011 miss  out  4  registered one-cycle pulse per column when a note leaves row 15 unhit.
REQ-012 busy  out  1  high while state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, FLUSH; SHIFT SHALL last exactly one cycle and then return to IDLE.
REQ-014 IDLE: flush=1 -> FLUSH (priority); else run=1 and tick_scroll=1 -> SHIFT; else stay.
REQ-015 tick_scroll in SHIFT or FLUSH, or with run=0, SHALL be dropped without effect.
REQ-016 SHIFT: rows[r+1] <= rows[r] for r=0..14; rows[0] <= pending pattern if pending valid else 4'b0; pending valid cleared.
REQ-017 SHIFT: miss SHALL equal rows[15] minus bits cleared by hits in that same cycle, presented on the following cycle.
REQ-018 Pending buffer SHALL hold one pattern; spawn_ready = !pending_valid && state != FLUSH; transfer occurs on spawn_valid && spawn_ready.
REQ-019 Transfer in the same cycle as SHIFT SHALL load pending; that pattern is inserted at the next SHIFT, not the current one.
REQ-020 Hits evaluated in IDLE and SHIFT when run=1: for each set hit_req[c], the highest-index row in the window 16-HIT_WIN..15 with bit c set SHALL be cleared and hit_ok[c] pulsed next cycle.
REQ-021 No note in the window for column c SHALL produce no clear and hit_ok[c]=0.
REQ-022 In SHIFT, hit clears SHALL apply to the pre-shift image before shifting.
REQ-023 FLUSH: 4-bit row counter starts at 0, zeroes one row per cycle, exits to IDLE after row 15 (16 cycles); pending buffer cleared on entry.
REQ-024 In FLUSH, hit_req SHALL be ignored and hit_ok/miss SHALL be 0; flush pulses are ignored.

Reset
REQ-025 On rst_n=0: state=IDLE, all rows 0, pending cleared, flush counter 0, block_rows=0, hit_ok=0, miss=0, busy=0, spawn_ready=1 after release.
REQ-026 Reset asserted mid-SHIFT or mid-FLUSH SHALL abort immediately to the reset values.

Configuration
REQ-027 Macro NOTE_SCORE_CNT_EN defined: outputs score_hits[15:0] and score_miss[15:0] SHALL exist.
REQ-028 score_hits adds popcount(hit_ok) per cycle; score_miss adds popcount(miss); both saturate at 16'hFFFF and are cleared by reset and on FLUSH entry.
REQ-029 Macro undefined: no counters and no score ports; all other behaviour is unchanged.

Structure
REQ-030 Shared package note_game_pkg SHALL hold: state enum, NUM_COLS=4, NUM_ROWS=16, row-pattern typedef (4 bits).
REQ-031 Combinational sub-module hit_judge SHALL compute the window search and per-column clear mask plus hit vector.

Verification
REQ-032 Spawn 4'b0001 then 16 ticks with run=1, no hits -> note reaches row 15 after tick 16; tick 17 -> miss=4'b0001 for one cycle.
REQ-033 Note in column 2 at row 14, HIT_WIN=2, hit_req=4'b0100 -> row 14 bit 2 cleared, hit_ok=4'b0100 next cycle, no later miss.
REQ-034 Column 1 notes at rows 14 and 15, single hit_req[1] -> only row 15 cleared; further tick moves row-14 note to 15.
REQ-035 hit_req[3] in the same cycle as SHIFT with a row-15 column-3 note -> hit_ok=4'b1000, miss=0.
REQ-036 Full field, flush pulse -> busy high 16 cycles, block_rows=0 at exit, ticks and hits during FLUSH have no effect.
REQ-037 spawn_valid held high with two patterns -> second accepted only after first consumed by a SHIFT; spawn_ready low in between.
